// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259A-compatible controller: sequencer states,
// OCW2 command encodings and the rotation helpers used by the priority logic.
package pic8259_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_ACK1 = 2'd1;
    localparam seq_state_t ST_ACK2 = 2'd2;

    localparam logic [2:0] OCW2_CLR_RAEOI  = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
    localparam logic [2:0] OCW2_NOP        = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
    localparam logic [2:0] OCW2_SET_RAEOI  = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

    function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} >> n;
        return t[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Picks the highest-priority set bit of request_i, where level
// priority_rotate_i+1 (mod 8) is highest; result is one-hot or zero.
module priority_resolver
    import pic8259_pkg::*;
(
    input  logic [7:0] request_i,
    input  logic [2:0] priority_rotate_i,
    output logic [7:0] grant_o
);

    logic [2:0] shift;
    logic [7:0] rotated;
    logic [7:0] isolated;

    always_comb begin
        shift    = priority_rotate_i + 3'd1;
        rotated  = rotate_right(request_i, shift);
        isolated = rotated & (~rotated + 8'd1);
        grant_o  = rotate_left(isolated, shift);
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt request / two-pulse INTA handshake sequencer with EOI, AEOI and
// OCW2-driven priority rotation control.
module interrupt_ack_sequencer
    import pic8259_pkg::*;
#(
    parameter int unsigned VECTOR_BASE_W = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [7:0]               interrupt_request_i,
    input  logic [7:0]               interrupt_mask_i,
    input  logic                     special_mask_mode_i,
    input  logic [7:0]               in_service_register_i,
    input  logic [7:0]               highest_level_in_service_i,
    input  logic [VECTOR_BASE_W-1:0] vector_base_i,
    input  logic                     auto_eoi_i,
    input  logic                     ocw2_write_i,
    input  logic [7:0]               ocw2_i,
    input  logic                     inta_n_i,
    output logic                     int_o,
    output logic                     latch_in_service_o,
    output logic [7:0]               ack_interrupt_o,
    output logic [7:0]               clear_irr_o,
    output logic [7:0]               end_of_interrupt_o,
    output logic [2:0]               priority_rotate_o,
    output logic [7:0]               data_out_o,
    output logic                     data_out_enable_o
);

    seq_state_t state_q, state_d;
    logic       inta_q;
    logic       int_q, int_d;
    logic       latch_q, latch_d;
    logic [7:0] ack_q, ack_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] eoi_q, eoi_d;
    logic [2:0] rot_q, rot_d;
    logic       raeoi_q, raeoi_d;
    logic [7:0] dout_q, dout_d;
    logic       den_q, den_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;

    logic [7:0] candidate;
    logic [2:0] top_shift;
    logic [7:0] cand_rot, hi_rot;
    logic       int_cond, inta_fall, inta_rise;

    priority_resolver u_resolver (
        .request_i         (interrupt_request_i & ~interrupt_mask_i),
        .priority_rotate_i (rot_q),
        .grant_o           (candidate)
    );

    // Once rotated so the highest level sits at bit 0, a smaller one-hot value outranks.
    always_comb begin
        top_shift = rot_q + 3'd1;
        cand_rot  = rotate_right(candidate, top_shift);
        hi_rot    = rotate_right(highest_level_in_service_i, top_shift);
        if (candidate == '0)
            int_cond = 1'b0;
        else if (special_mask_mode_i)
            int_cond = (candidate & in_service_register_i) == '0;
        else
            int_cond = (hi_rot == '0) || (cand_rot < hi_rot);
        inta_fall = inta_q & ~inta_n_i;
        inta_rise = ~inta_q & inta_n_i;
    end

    always_comb begin
        state_d    = state_q;
        int_d      = 1'b0;
        latch_d    = 1'b0;
        ack_d      = '0;
        clr_d      = '0;
        eoi_d      = '0;
        rot_d      = rot_q;
        raeoi_d    = raeoi_q;
        dout_d     = dout_q;
        den_d      = den_q;
        level_d    = level_q;
        spurious_d = spurious_q;

        case (state_q)
            ST_IDLE: begin
                int_d = int_cond;
                if (inta_fall) begin
                    int_d   = 1'b0;
                    state_d = ST_ACK1;
                    if (candidate != '0) begin
                        level_d    = onehot_index(candidate);
                        spurious_d = 1'b0;
                        latch_d    = 1'b1;
                        ack_d      = candidate;
                        clr_d      = candidate;
                    end else begin
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                    dout_d  = 8'({vector_base_i, level_q});
                    den_d   = 1'b1;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_d = ST_IDLE;
                    den_d   = 1'b0;
                    if (auto_eoi_i && !spurious_q) begin
                        eoi_d = 8'd1 << level_q;
                        if (raeoi_q) rot_d = level_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // OCW2 is applied after the handshake so its rotate overrides an AEOI rotate.
        if (ocw2_write_i) begin
            case (ocw2_i[7:5])
                OCW2_NS_EOI:     eoi_d = eoi_d | highest_level_in_service_i;
                OCW2_SP_EOI:     eoi_d = eoi_d | (8'd1 << ocw2_i[2:0]);
                OCW2_ROT_NS_EOI: begin
                    eoi_d = eoi_d | highest_level_in_service_i;
                    if (highest_level_in_service_i != '0)
                        rot_d = onehot_index(highest_level_in_service_i);
                end
                OCW2_ROT_SP_EOI: begin
                    eoi_d = eoi_d | (8'd1 << ocw2_i[2:0]);
                    rot_d = ocw2_i[2:0];
                end
                OCW2_SET_PRIO:   rot_d   = ocw2_i[2:0];
                OCW2_SET_RAEOI:  raeoi_d = 1'b1;
                OCW2_CLR_RAEOI:  raeoi_d = 1'b0;
                OCW2_NOP:        ;
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            inta_q     <= 1'b1;
            int_q      <= 1'b0;
            latch_q    <= 1'b0;
            ack_q      <= '0;
            clr_q      <= '0;
            eoi_q      <= '0;
            rot_q      <= 3'd7;
            raeoi_q    <= 1'b0;
            dout_q     <= '0;
            den_q      <= 1'b0;
            level_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_n_i;
            int_q      <= int_d;
            latch_q    <= latch_d;
            ack_q      <= ack_d;
            clr_q      <= clr_d;
            eoi_q      <= eoi_d;
            rot_q      <= rot_d;
            raeoi_q    <= raeoi_d;
            dout_q     <= dout_d;
            den_q      <= den_d;
            level_q    <= level_d;
            spurious_q <= spurious_d;
        end
    end

    assign int_o              = int_q;
    assign latch_in_service_o = latch_q;
    assign ack_interrupt_o    = ack_q;
    assign clear_irr_o        = clr_q;
    assign end_of_interrupt_o = eoi_q;
    assign priority_rotate_o  = rot_q;
    assign data_out_o         = dout_q;
    assign data_out_enable_o  = den_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench: directed handshake scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] interrupt_request_i, interrupt_mask_i;
    logic       special_mask_mode_i;
    logic [7:0] in_service_register_i, highest_level_in_service_i;
    logic [4:0] vector_base_i;
    logic       auto_eoi_i, ocw2_write_i;
    logic [7:0] ocw2_i;
    logic       inta_n_i;
    logic       int_o, latch_in_service_o, data_out_enable_o;
    logic [7:0] ack_interrupt_o, clear_irr_o, end_of_interrupt_o, data_out_o;
    logic [2:0] priority_rotate_o;

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.VECTOR_BASE_W(5)) dut (
        .clk_i                      (clk),
        .reset_i                    (reset_i),
        .interrupt_request_i        (interrupt_request_i),
        .interrupt_mask_i           (interrupt_mask_i),
        .special_mask_mode_i        (special_mask_mode_i),
        .in_service_register_i      (in_service_register_i),
        .highest_level_in_service_i (highest_level_in_service_i),
        .vector_base_i              (vector_base_i),
        .auto_eoi_i                 (auto_eoi_i),
        .ocw2_write_i               (ocw2_write_i),
        .ocw2_i                     (ocw2_i),
        .inta_n_i                   (inta_n_i),
        .int_o                      (int_o),
        .latch_in_service_o         (latch_in_service_o),
        .ack_interrupt_o            (ack_interrupt_o),
        .clear_irr_o                (clear_irr_o),
        .end_of_interrupt_o         (end_of_interrupt_o),
        .priority_rotate_o          (priority_rotate_o),
        .data_out_o                 (data_out_o),
        .data_out_enable_o          (data_out_enable_o)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: handshake phase 0/1/2, acknowledged level, rotation as ints.
    int   m_phase, m_prev_inta, m_lvl, m_spur, m_rot, m_raeoi;
    logic       e_int, e_latch, e_den;
    logic [7:0] e_ack, e_clr, e_eoi, e_dout;

    function automatic int pick(input logic [7:0] req, input int rot);
        for (int k = 1; k <= 8; k++) begin
            if (req[(rot + k) % 8]) return (rot + k) % 8;
        end
        return -1;
    endfunction

    function automatic int rank(input int lvl, input int rot);
        return (lvl - rot + 7) % 8;
    endfunction

    function automatic int idx_of(input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic wants(input int cand);
        int hl;
        if (cand < 0) return 1'b0;
        if (special_mask_mode_i) return !in_service_register_i[cand];
        hl = idx_of(highest_level_in_service_i);
        if (hl < 0) return 1'b1;
        return rank(cand, m_rot) < rank(hl, m_rot);
    endfunction

    task automatic model_step();
        int  cand, nrot, hl, sl;
        bit  fall, rise;
        if (reset_i) begin
            m_phase = 0; m_prev_inta = 1; m_rot = 7; m_raeoi = 0; m_lvl = 0; m_spur = 0;
            e_int = 0; e_latch = 0; e_ack = 0; e_clr = 0; e_eoi = 0; e_dout = 0; e_den = 0;
            return;
        end
        e_latch = 0; e_ack = 0; e_clr = 0; e_eoi = 0;
        fall = (m_prev_inta == 1) && !inta_n_i;
        rise = (m_prev_inta == 0) && inta_n_i;
        nrot = m_rot;
        cand = pick(interrupt_request_i & ~interrupt_mask_i, m_rot);
        if (m_phase == 0) begin
            if (fall) begin
                e_int = 0;
                m_phase = 1;
                if (cand >= 0) begin
                    m_lvl = cand; m_spur = 0;
                    e_latch = 1; e_ack = 8'(1 << cand); e_clr = 8'(1 << cand);
                end else begin
                    m_lvl = 7; m_spur = 1;
                end
            end else begin
                e_int = wants(cand);
            end
        end else if (m_phase == 1) begin
            e_int = 0;
            if (fall) begin
                m_phase = 2;
                e_dout = {vector_base_i, 3'(m_lvl)};
                e_den = 1;
            end
        end else begin
            e_int = 0;
            if (rise) begin
                m_phase = 0;
                e_den = 0;
                if (auto_eoi_i && !m_spur) begin
                    e_eoi = 8'(1 << m_lvl);
                    if (m_raeoi != 0) nrot = m_lvl;
                end
            end
        end
        if (ocw2_write_i) begin
            hl = idx_of(highest_level_in_service_i);
            sl = int'(ocw2_i[2:0]);
            case (int'(ocw2_i[7:5]))
                1: if (hl >= 0) e_eoi |= 8'(1 << hl);
                3: e_eoi |= 8'(1 << sl);
                5: if (hl >= 0) begin e_eoi |= 8'(1 << hl); nrot = hl; end
                7: begin e_eoi |= 8'(1 << sl); nrot = sl; end
                6: nrot = sl;
                4: m_raeoi = 1;
                0: m_raeoi = 0;
                default: ;
            endcase
        end
        m_rot = nrot;
        m_prev_inta = inta_n_i ? 1 : 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_val("int", {31'd0, int_o}, {31'd0, e_int});
        check_val("latch_in_service", {31'd0, latch_in_service_o}, {31'd0, e_latch});
        check_val("ack_interrupt", {24'd0, ack_interrupt_o}, {24'd0, e_ack});
        check_val("clear_irr", {24'd0, clear_irr_o}, {24'd0, e_clr});
        check_val("end_of_interrupt", {24'd0, end_of_interrupt_o}, {24'd0, e_eoi});
        check_val("priority_rotate", {29'd0, priority_rotate_o}, 32'(m_rot));
        check_val("data_out", {24'd0, data_out_o}, {24'd0, e_dout});
        check_val("data_out_enable", {31'd0, data_out_enable_o}, {31'd0, e_den});
        @(negedge clk);
    endtask

    initial begin
        int r;
        reset_i = 1; interrupt_request_i = 0; interrupt_mask_i = 0; special_mask_mode_i = 0;
        in_service_register_i = 0; highest_level_in_service_i = 0; vector_base_i = 5'h01;
        auto_eoi_i = 0; ocw2_write_i = 0; ocw2_i = 0; inta_n_i = 1;

        // Reset
        cycle(); cycle();
        check_val("rst_rotate", {29'd0, priority_rotate_o}, 32'd7);
        check_val("rst_int", {31'd0, int_o}, 32'd0);
        reset_i = 0;

        // Basic acknowledge
        interrupt_request_i = 8'h24;
        cycle();
        check_val("basic_int", {31'd0, int_o}, 32'd1);
        inta_n_i = 0; cycle();
        check_val("basic_latch", {31'd0, latch_in_service_o}, 32'd1);
        check_val("basic_ack", {24'd0, ack_interrupt_o}, 32'h04);
        check_val("basic_clr", {24'd0, clear_irr_o}, 32'h04);
        interrupt_request_i = 8'h20; in_service_register_i = 8'h04; highest_level_in_service_i = 8'h04;
        inta_n_i = 1; cycle();
        inta_n_i = 0; cycle();
        check_val("basic_den", {31'd0, data_out_enable_o}, 32'd1);
        check_val("basic_dout", {24'd0, data_out_o}, 32'h0A);
        inta_n_i = 1; cycle();
        check_val("basic_den_drop", {31'd0, data_out_enable_o}, 32'd0);

        // Nesting
        in_service_register_i = 8'h02; highest_level_in_service_i = 8'h02; interrupt_request_i = 8'h08;
        cycle(); cycle();
        check_val("nest_blocked", {31'd0, int_o}, 32'd0);
        interrupt_request_i = 8'h01; cycle();
        check_val("nest_higher", {31'd0, int_o}, 32'd1);
        interrupt_request_i = 8'h08; special_mask_mode_i = 1; cycle();
        check_val("nest_smm", {31'd0, int_o}, 32'd1);
        special_mask_mode_i = 0; interrupt_request_i = 0;

        // Rotate on non-specific EOI, then restore rotation
        in_service_register_i = 8'h10; highest_level_in_service_i = 8'h10;
        ocw2_write_i = 1; ocw2_i = 8'hA0; cycle();
        check_val("rot_eoi", {24'd0, end_of_interrupt_o}, 32'h10);
        check_val("rot_prio", {29'd0, priority_rotate_o}, 32'd4);
        in_service_register_i = 0; highest_level_in_service_i = 0;
        ocw2_i = 8'h20; cycle();
        check_val("ns_eoi_empty", {24'd0, end_of_interrupt_o}, 32'h00);
        check_val("ns_eoi_empty_rot", {29'd0, priority_rotate_o}, 32'd4);
        ocw2_i = 8'hC7; cycle();
        ocw2_write_i = 0;

        // Spurious
        interrupt_request_i = 8'h01; cycle();
        interrupt_request_i = 8'h00; cycle();
        inta_n_i = 0; cycle();
        check_val("spur_latch", {31'd0, latch_in_service_o}, 32'd0);
        inta_n_i = 1; cycle();
        inta_n_i = 0; cycle();
        check_val("spur_dout", {24'd0, data_out_o}, 32'h0F);
        inta_n_i = 1; cycle();

        // AEOI with rotate
        auto_eoi_i = 1; ocw2_write_i = 1; ocw2_i = 8'h80; cycle();
        ocw2_write_i = 0; interrupt_request_i = 8'h08; cycle();
        inta_n_i = 0; cycle();
        check_val("aeoi_ack", {24'd0, ack_interrupt_o}, 32'h08);
        interrupt_request_i = 0;
        inta_n_i = 1; cycle();
        inta_n_i = 0; cycle();
        inta_n_i = 1; cycle();
        check_val("aeoi_eoi", {24'd0, end_of_interrupt_o}, 32'h08);
        check_val("aeoi_rot", {29'd0, priority_rotate_o}, 32'd3);

        // Random traffic, including mid-handshake resets and stray INTA edges
        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            interrupt_request_i = 8'($urandom);
            interrupt_mask_i = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            special_mask_mode_i = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 8);
            highest_level_in_service_i = (r == 8) ? 8'h00 : 8'(1 << r);
            in_service_register_i = 8'($urandom) | highest_level_in_service_i;
            vector_base_i = 5'($urandom);
            auto_eoi_i = ($urandom_range(0, 1) != 0);
            ocw2_write_i = ($urandom_range(0, 5) == 0);
            ocw2_i = 8'($urandom);
            if ($urandom_range(0, 2) == 0) inta_n_i = ~inta_n_i;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Control sequencer for the 8259A-compatible interrupt controller. It sits between the request/mask registers, the in-service register block and the CPU bus. It decides when to raise `int` and runs the two-pulse 8086-mode INTA handshake. It drives the in-service latch, end-of-interrupt clears and priority rotation, and handles OCW2 EOI/rotate commands.

## Interface
- `VECTOR_BASE_W`, default 5: width of the ICW2 vector base field.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `interrupt_request` input 8: IRR contents.
- `interrupt_mask` input 8: IMR, 1 = masked.
- `special_mask_mode` input 1: in-service levels do not block lower levels.
- `in_service_register` input 8: current ISR.
- `highest_level_in_service` input 8: one-hot highest ISR level under current rotation.
- `vector_base` input VECTOR_BASE_W: ICW2 T7..T3.
- `auto_eoi` input 1: ICW4 AEOI mode.
- `ocw2_write` input 1: one-cycle strobe; `ocw2` input 8 is valid with it.
- `inta_n` input 1: CPU acknowledge, already synchronous to `clk`.
- `int` output 1: interrupt request to CPU.
- `latch_in_service` output 1: one-cycle pulse; `ack_interrupt` output 8 is the one-hot level to set in the ISR.
- `clear_irr` output 8: one-cycle pulse clearing the edge-latched IRR bit.
- `end_of_interrupt` output 8: one-cycle pulse with the ISR bit(s) to clear.
- `priority_rotate` output 3: lowest-priority level; IR(`priority_rotate`+1 mod 8) is highest.
- `data_out` output 8: vector byte; `data_out_enable` output 1: bus drive enable.

## Operation
- Candidate = resolve(`interrupt_request` & ~`interrupt_mask`) under `priority_rotate`.
- `int` is set in IDLE when the candidate is nonzero and outranks `highest_level_in_service` under rotation. When `special_mask_mode`=1, only a candidate equal to an in-service level is blocked.
- States: IDLE, ACK1, ACK2.
- **IDLE → ACK1** on the first `inta_n` falling edge, detected against a registered copy.
  - `int` clears.
  - Acknowledged level = candidate, captured.
  - If candidate≠0: pulse `latch_in_service` and `clear_irr`, with `ack_interrupt` = that level.
  - If candidate=0 (spurious): record level 7 and pulse nothing.
- **ACK1 → ACK2** on the second falling edge.
  - `data_out` = {`vector_base`, level[2:0]}.
  - `data_out_enable` is 1 while `inta_n`=0.
- **ACK2 → IDLE** on the `inta_n` rising edge.
  - `data_out_enable` drops.
  - If `auto_eoi`=1 and the request was not spurious: pulse `end_of_interrupt` = level.
  - If rotate-in-AEOI is also set: `priority_rotate` = level.
- OCW2 decode on `ocw2[7:5]`; each command is processed in any state:
  - 001: clear `highest_level_in_service`.
  - 011: clear bit `ocw2[2:0]`.
  - 101: as 001, then `priority_rotate` = cleared level.
  - 111: as 011, then `priority_rotate` = `ocw2[2:0]`.
  - 110: `priority_rotate` = `ocw2[2:0]`.
  - 100: set rotate-in-AEOI.
  - 000: clear rotate-in-AEOI.
  - 010: no-op.
  - A non-specific EOI with ISR empty pulses zero and leaves rotation unchanged.
- Simultaneous OCW2 EOI and AEOI in one cycle: `end_of_interrupt` carries the OR of both. A rotate from OCW2 wins.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `int`, `latch_in_service`, `ack_interrupt`, `clear_irr`, `end_of_interrupt`, `data_out`, `data_out_enable` all 0.
  - `priority_rotate`=7; rotate-in-AEOI=0.
- `int` follows input changes one cycle later, in IDLE only.
- Edge pulses (`latch_in_service`, `clear_irr`, AEOI `end_of_interrupt`) assert in the cycle after the clock edge that first samples the edge.
- OCW2 effects appear in the cycle after `ocw2_write`.
- `reset` mid-handshake returns to IDLE immediately; the partial acknowledge is abandoned.
- Extra `inta_n` edges in states with no defined transition are ignored.

## Structure
- Shared package `pic8259_pkg`:
  - OCW2 command encodings.
  - State typedef.
  - `rotate_right`/`rotate_left` functions.
- Sub-module `priority_resolver`, also reused by ISR: combinational rotate-right, lowest-bit-first resolve, rotate-left, all by `priority_rotate`.

## Test plan
- **Reset:** assert for 2 cycles → all outputs 0, `priority_rotate`=7.
- **Basic acknowledge:**
  - Stimulus: IRR=0x24, IMR=0, ISR=0, `vector_base`=0x01.
  - `int`=1.
  - First INTA → `latch_in_service`, `ack_interrupt`=0x04, `clear_irr`=0x04.
  - Second INTA → `data_out`=0x0A while `data_out_enable`=1.
- **Nesting:**
  - ISR=0x02 and highest=0x02, IRR=0x08 → `int` stays 0.
  - IRR=0x01 → `int`=1.
  - With `special_mask_mode`=1 and IRR=0x08 → `int`=1.
- **Rotate on non-specific EOI:** highest=0x10, OCW2=0xA0 → `end_of_interrupt`=0x10, `priority_rotate`=4.
- **Spurious:**
  - IRR drops to 0 before the first INTA → no latch.
  - `data_out`={`vector_base`,3'b111}.
- **AEOI with rotate:**
  - `auto_eoi`=1, OCW2=0x80, acknowledge IR3.
  - At the second INTA rising edge → `end_of_interrupt`=0x08, `priority_rotate`=3.
